// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch stage: PC, address translation, single-outstanding
// instruction bus master and a one-entry skid buffer towards decode.
module eco32f_fetch #(
    parameter logic [31:0] RESET_PC = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        if_user_mode,
    output logic [31:0] itlb_vaddr,
    input  logic [31:0] itlb_paddr,
    input  logic        itlb_miss,
    input  logic        itlb_invalid,
    output logic        ibus_req_o,
    output logic [31:0] ibus_adr_o,
    input  logic        ibus_ack_i,
    input  logic        ibus_err_i,
    input  logic [31:0] ibus_dat_i,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_insn,
    output logic        id_exc_ibus_fault,
    output logic        id_exc_itlb_kmiss,
    output logic        id_exc_itlb_umiss,
    output logic        id_exc_itlb_invalid,
    output logic        id_exc_itlb_priv
);

    typedef enum logic [1:0] {RUN, BUF, DISCARD, HALT} state_t;

    // Exception vector layout: {ibus_fault, kmiss, umiss, invalid, priv}
    localparam logic [4:0] EXC_FAULT = 5'b10000;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_n;
    logic [31:0] adr_n;
    logic        id_valid_n;
    logic [31:0] id_pc_n, id_insn_n;
    logic [4:0]  id_exc, id_exc_n;
    logic        buf_valid, buf_valid_n;
    logic [31:0] buf_pc, buf_pc_n, buf_insn, buf_insn_n;
    logic [4:0]  buf_exc, buf_exc_n;

    logic        slot_free, bus_wait, ack_hit, err_hit;
    logic [31:0] va, paddr;
    logic        direct, priv;
    logic [4:0]  exc_va;
    logic        issue, id_free, mark;
    logic [31:0] mark_pc;
    logic [4:0]  mark_exc;

    assign slot_free = !id_valid || !id_stall;
    assign ack_hit   = ibus_req_o && ibus_ack_i && !ibus_err_i;
    assign err_hit   = ibus_req_o && ibus_err_i;
    assign bus_wait  = ibus_req_o && !ibus_ack_i && !ibus_err_i;

    always_comb begin
        if (ex_redirect)
            va = ex_redirect_pc;
        else if ((state == RUN && ack_hit && slot_free) || (state == BUF && !id_stall))
            va = pc + 32'd4;
        else
            va = pc;
    end

    assign itlb_vaddr = va;

    // The top quarter of the address space is a fixed kernel window; everything else goes through the ITLB.
    always_comb begin
        direct    = (va[31:30] == 2'b11);
        paddr     = direct ? {2'b00, va[29:0]} : itlb_paddr;
        priv      = if_user_mode && va[31];
        exc_va    = 5'b0;
        exc_va[0] = priv;
        exc_va[3] = !direct && !priv && itlb_miss && va[31];
        exc_va[2] = !direct && !priv && itlb_miss && !va[31];
        exc_va[1] = !direct && !priv && !itlb_miss && itlb_invalid;
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_n       = ibus_req_o;
        adr_n       = ibus_adr_o;
        id_valid_n  = id_valid;
        id_pc_n     = id_pc;
        id_insn_n   = id_insn;
        id_exc_n    = id_exc;
        buf_valid_n = buf_valid;
        buf_pc_n    = buf_pc;
        buf_insn_n  = buf_insn;
        buf_exc_n   = buf_exc;
        issue       = 1'b0;
        id_free     = slot_free;
        mark        = 1'b0;
        mark_pc     = pc;
        mark_exc    = 5'b0;

        if (slot_free) begin
            id_valid_n = 1'b0;
            id_insn_n  = 32'b0;
            id_exc_n   = 5'b0;
        end

        if (ex_redirect) begin
            id_valid_n  = 1'b0;
            id_insn_n   = 32'b0;
            id_exc_n    = 5'b0;
            buf_valid_n = 1'b0;
            buf_exc_n   = 5'b0;
            id_free     = 1'b1;
            pc_n        = ex_redirect_pc;
            if (bus_wait)
                state_n = DISCARD;
            else
                issue = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (!ibus_req_o) begin
                        issue = 1'b1;
                    end else if (err_hit) begin
                        mark     = 1'b1;
                        mark_pc  = pc;
                        mark_exc = EXC_FAULT;
                        req_n    = 1'b0;
                        state_n  = HALT;
                    end else if (ack_hit) begin
                        if (slot_free) begin
                            id_valid_n = 1'b1;
                            id_pc_n    = pc;
                            id_insn_n  = ibus_dat_i;
                            id_exc_n   = 5'b0;
                            id_free    = 1'b0;
                            issue      = 1'b1;
                        end else begin
                            buf_valid_n = 1'b1;
                            buf_pc_n    = pc;
                            buf_insn_n  = ibus_dat_i;
                            buf_exc_n   = 5'b0;
                            req_n       = 1'b0;
                            state_n     = BUF;
                        end
                    end
                end
                BUF: begin
                    if (!id_stall) begin
                        id_valid_n  = 1'b1;
                        id_pc_n     = buf_pc;
                        id_insn_n   = buf_insn;
                        id_exc_n    = buf_exc;
                        buf_valid_n = 1'b0;
                        id_free     = 1'b0;
                        issue       = 1'b1;
                    end
                end
                DISCARD: begin
                    if (ibus_req_o && (ibus_ack_i || ibus_err_i))
                        issue = 1'b1;
                end
                HALT: begin
                    if (buf_valid && id_free) begin
                        id_valid_n  = 1'b1;
                        id_pc_n     = buf_pc;
                        id_insn_n   = buf_insn;
                        id_exc_n    = buf_exc;
                        buf_valid_n = 1'b0;
                        id_free     = 1'b0;
                    end
                end
            endcase
        end

        // A faulting fetch address produces a marker instead of a bus request.
        if (issue) begin
            pc_n = va;
            if (|exc_va) begin
                req_n    = 1'b0;
                state_n  = HALT;
                mark     = 1'b1;
                mark_pc  = va;
                mark_exc = exc_va;
            end else begin
                req_n   = 1'b1;
                adr_n   = paddr;
                state_n = RUN;
            end
        end

        if (mark) begin
            if (id_free) begin
                id_valid_n = 1'b1;
                id_pc_n    = mark_pc;
                id_insn_n  = 32'b0;
                id_exc_n   = mark_exc;
            end else begin
                buf_valid_n = 1'b1;
                buf_pc_n    = mark_pc;
                buf_insn_n  = 32'b0;
                buf_exc_n   = mark_exc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ibus_req_o <= 1'b0;
            ibus_adr_o <= 32'b0;
            id_valid   <= 1'b0;
            id_pc      <= 32'b0;
            id_insn    <= 32'b0;
            id_exc     <= 5'b0;
            buf_valid  <= 1'b0;
            buf_pc     <= 32'b0;
            buf_insn   <= 32'b0;
            buf_exc    <= 5'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ibus_req_o <= req_n;
            ibus_adr_o <= adr_n;
            id_valid   <= id_valid_n;
            id_pc      <= id_pc_n;
            id_insn    <= id_insn_n;
            id_exc     <= id_exc_n;
            buf_valid  <= buf_valid_n;
            buf_pc     <= buf_pc_n;
            buf_insn   <= buf_insn_n;
            buf_exc    <= buf_exc_n;
        end
    end

    assign id_exc_ibus_fault   = id_exc[4];
    assign id_exc_itlb_kmiss   = id_exc[3];
    assign id_exc_itlb_umiss   = id_exc[2];
    assign id_exc_itlb_invalid = id_exc[1];
    assign id_exc_itlb_priv    = id_exc[0];

endmodule

// File: tb/tb_eco32f_fetch.sv
// Directed testbench for eco32f_fetch; the ITLB maps va to {4'h1, va[27:0]}.
module tb_eco32f_fetch;

    logic        clk, rst;
    logic        id_stall, ex_redirect, if_user_mode;
    logic [31:0] ex_redirect_pc;
    logic [31:0] itlb_vaddr, itlb_paddr;
    logic        itlb_miss, itlb_invalid;
    logic        ibus_req_o, ibus_ack_i, ibus_err_i;
    logic [31:0] ibus_adr_o, ibus_dat_i;
    logic        id_valid;
    logic [31:0] id_pc, id_insn;
    logic        id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss;
    logic        id_exc_itlb_invalid, id_exc_itlb_priv;
    logic [4:0]  exc;

    int n_checks = 0;
    int n_fail   = 0;

    eco32f_fetch dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .ex_redirect(ex_redirect),
        .ex_redirect_pc(ex_redirect_pc), .if_user_mode(if_user_mode),
        .itlb_vaddr(itlb_vaddr), .itlb_paddr(itlb_paddr), .itlb_miss(itlb_miss),
        .itlb_invalid(itlb_invalid), .ibus_req_o(ibus_req_o), .ibus_adr_o(ibus_adr_o),
        .ibus_ack_i(ibus_ack_i), .ibus_err_i(ibus_err_i), .ibus_dat_i(ibus_dat_i),
        .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
        .id_exc_ibus_fault(id_exc_ibus_fault), .id_exc_itlb_kmiss(id_exc_itlb_kmiss),
        .id_exc_itlb_umiss(id_exc_itlb_umiss), .id_exc_itlb_invalid(id_exc_itlb_invalid),
        .id_exc_itlb_priv(id_exc_itlb_priv)
    );

    assign itlb_paddr = {4'h1, itlb_vaddr[27:0]};
    assign exc = {id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss,
                  id_exc_itlb_invalid, id_exc_itlb_priv};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({ibus_req_o, ibus_adr_o} !== {1'b1 ^ 1'b1, 32'h0})
            begin n_fail++; $display("FAIL reset_bus: got req=%b adr=%h, want req=0 adr=00000000", ibus_req_o, ibus_adr_o); end
        n_checks++;
        if ({id_valid, id_pc, id_insn, exc} !== {1'b0, 32'h0, 32'h0, 5'b0})
            begin n_fail++; $display("FAIL reset_id: got v=%b pc=%h insn=%h exc=%b, want all zero", id_valid, id_pc, id_insn, exc); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (itlb_vaddr !== 32'hE000_0000)
            begin n_fail++; $display("FAIL reset_vaddr: got %h, want e0000000", itlb_vaddr); end
        tick();
        n_checks++;
        if ({ibus_req_o, ibus_adr_o, id_valid} !== {1'b1, 32'h2000_0000, 1'b0})
            begin n_fail++; $display("FAIL first_req: got req=%b adr=%h v=%b, want req=1 adr=20000000 v=0", ibus_req_o, ibus_adr_o, id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc, exp_adr;
        ibus_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ibus_dat_i = 32'h1111_0000 + i;
            exp_pc  = 32'hE000_0000 + 32'(4 * i);
            exp_adr = 32'h2000_0004 + 32'(4 * i);
            tick();
            n_checks++;
            if ({id_valid, id_pc, id_insn, exc} !== {1'b1, exp_pc, 32'h1111_0000 + i, 5'b0})
                begin n_fail++; $display("FAIL stream_id%0d: got v=%b pc=%h insn=%h exc=%b, want v=1 pc=%h insn=%h", i, id_valid, id_pc, id_insn, exc, exp_pc, 32'h1111_0000 + i); end
            n_checks++;
            if ({ibus_req_o, ibus_adr_o} !== {1'b1, exp_adr})
                begin n_fail++; $display("FAIL stream_adr%0d: got req=%b adr=%h, want req=1 adr=%h", i, ibus_req_o, ibus_adr_o, exp_adr); end
        end
        ibus_ack_i = 1'b0;
        tick();
        n_checks++;
        if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h2000_000C})
            begin n_fail++; $display("FAIL stream_idle: got v=%b req=%b adr=%h, want v=0 req=1 adr=2000000c", id_valid, ibus_req_o, ibus_adr_o); end
    endtask

    task automatic test_stall();
        ibus_ack_i = 1'b1;
        ibus_dat_i = 32'h1111_0003;
        tick();
        n_checks++;
        if ({id_valid, id_pc, id_insn, ibus_adr_o} !== {1'b1, 32'hE000_000C, 32'h1111_0003, 32'h2000_0010})
            begin n_fail++; $display("FAIL stall_pre: got v=%b pc=%h insn=%h adr=%h, want v=1 pc=e000000c insn=11110003 adr=20000010", id_valid, id_pc, id_insn, ibus_adr_o); end
        id_stall   = 1'b1;
        ibus_dat_i = 32'h1111_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            ibus_ack_i = 1'b0;
            n_checks++;
            if ({id_valid, id_pc, id_insn, ibus_req_o} !== {1'b1, 32'hE000_000C, 32'h1111_0003, 1'b0})
                begin n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h insn=%h req=%b, want v=1 pc=e000000c insn=11110003 req=0", i, id_valid, id_pc, id_insn, ibus_req_o); end
        end
        id_stall = 1'b0;
        tick();
        n_checks++;
        if ({id_valid, id_pc, id_insn} !== {1'b1, 32'hE000_0010, 32'h1111_0004})
            begin n_fail++; $display("FAIL stall_release_id: got v=%b pc=%h insn=%h, want v=1 pc=e0000010 insn=11110004", id_valid, id_pc, id_insn); end
        n_checks++;
        if ({ibus_req_o, ibus_adr_o} !== {1'b1, 32'h2000_0014})
            begin n_fail++; $display("FAIL stall_release_adr: got req=%b adr=%h, want req=1 adr=20000014", ibus_req_o, ibus_adr_o); end
        tick();
        n_checks++;
        if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h2000_0014})
            begin n_fail++; $display("FAIL stall_after: got v=%b req=%b adr=%h, want v=0 req=1 adr=20000014", id_valid, ibus_req_o, ibus_adr_o); end
    endtask

    task automatic test_redirect_discard();
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'hE000_1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            ex_redirect = 1'b0;
            n_checks++;
            if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h2000_0014})
                begin n_fail++; $display("FAIL discard_hold%0d: got v=%b req=%b adr=%h, want v=0 req=1 adr=20000014", i, id_valid, ibus_req_o, ibus_adr_o); end
        end
        ibus_ack_i = 1'b1;
        ibus_dat_i = 32'hDEAD_BEEF;
        tick();
        ibus_ack_i = 1'b0;
        n_checks++;
        if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h2000_1000})
            begin n_fail++; $display("FAIL discard_drop: got v=%b req=%b adr=%h, want v=0 req=1 adr=20001000", id_valid, ibus_req_o, ibus_adr_o); end
        tick();
        n_checks++;
        if ({id_valid, ibus_adr_o} !== {1'b0, 32'h2000_1000})
            begin n_fail++; $display("FAIL discard_wait: got v=%b adr=%h, want v=0 adr=20001000", id_valid, ibus_adr_o); end
        ibus_ack_i = 1'b1;
        ibus_dat_i = 32'h1111_0005;
        tick();
        ibus_ack_i = 1'b0;
        n_checks++;
        if ({id_valid, id_pc, id_insn, ibus_adr_o} !== {1'b1, 32'hE000_1000, 32'h1111_0005, 32'h2000_1004})
            begin n_fail++; $display("FAIL discard_target: got v=%b pc=%h insn=%h adr=%h, want v=1 pc=e0001000 insn=11110005 adr=20001004", id_valid, id_pc, id_insn, ibus_adr_o); end
    endtask

    task automatic test_redirect_ack();
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'hE000_2000;
        ibus_ack_i     = 1'b1;
        ibus_dat_i     = 32'hDEAD_BEEF;
        tick();
        ex_redirect = 1'b0;
        n_checks++;
        if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h2000_2000})
            begin n_fail++; $display("FAIL redir_ack: got v=%b req=%b adr=%h, want v=0 req=1 adr=20002000", id_valid, ibus_req_o, ibus_adr_o); end
        ibus_dat_i = 32'h1111_0006;
        tick();
        ibus_ack_i = 1'b0;
        n_checks++;
        if ({id_valid, id_pc, id_insn, ibus_adr_o} !== {1'b1, 32'hE000_2000, 32'h1111_0006, 32'h2000_2004})
            begin n_fail++; $display("FAIL redir_ack_next: got v=%b pc=%h insn=%h adr=%h, want v=1 pc=e0002000 insn=11110006 adr=20002004", id_valid, id_pc, id_insn, ibus_adr_o); end
    endtask

    task automatic test_tlb_faults();
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h0040_0000;
        itlb_miss      = 1'b1;
        ibus_ack_i     = 1'b1;
        ibus_dat_i     = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (itlb_vaddr !== 32'h0040_0000)
            begin n_fail++; $display("FAIL umiss_vaddr: got %h, want 00400000", itlb_vaddr); end
        tick();
        ex_redirect = 1'b0;
        ibus_ack_i  = 1'b0;
        itlb_miss   = 1'b0;
        n_checks++;
        if ({ibus_req_o, id_valid, id_pc, id_insn, exc} !== {1'b0, 1'b1, 32'h0040_0000, 32'h0, 5'b00100})
            begin n_fail++; $display("FAIL umiss_marker: got req=%b v=%b pc=%h insn=%h exc=%b, want req=0 v=1 pc=00400000 insn=0 exc=00100", ibus_req_o, id_valid, id_pc, id_insn, exc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({ibus_req_o, id_valid} !== 2'b00)
                begin n_fail++; $display("FAIL umiss_halt%0d: got req=%b v=%b, want req=0 v=0", i, ibus_req_o, id_valid); end
        end
        if_user_mode   = 1'b1;
        itlb_miss      = 1'b1;
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h8000_0000;
        tick();
        ex_redirect  = 1'b0;
        if_user_mode = 1'b0;
        n_checks++;
        if ({ibus_req_o, id_valid, id_pc, id_insn, exc} !== {1'b0, 1'b1, 32'h8000_0000, 32'h0, 5'b00001})
            begin n_fail++; $display("FAIL priv_marker: got req=%b v=%b pc=%h insn=%h exc=%b, want req=0 v=1 pc=80000000 insn=0 exc=00001", ibus_req_o, id_valid, id_pc, id_insn, exc); end
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        itlb_miss   = 1'b0;
        n_checks++;
        if ({ibus_req_o, id_valid, id_pc, exc} !== {1'b0, 1'b1, 32'h8000_0000, 5'b01000})
            begin n_fail++; $display("FAIL kmiss_marker: got req=%b v=%b pc=%h exc=%b, want req=0 v=1 pc=80000000 exc=01000", ibus_req_o, id_valid, id_pc, exc); end
        itlb_invalid   = 1'b1;
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h0000_1000;
        tick();
        ex_redirect  = 1'b0;
        itlb_invalid = 1'b0;
        n_checks++;
        if ({ibus_req_o, id_valid, id_pc, exc} !== {1'b0, 1'b1, 32'h0000_1000, 5'b00010})
            begin n_fail++; $display("FAIL invalid_marker: got req=%b v=%b pc=%h exc=%b, want req=0 v=1 pc=00001000 exc=00010", ibus_req_o, id_valid, id_pc, exc); end
    endtask

    task automatic test_mapped_err();
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h0040_0000;
        tick();
        ex_redirect = 1'b0;
        n_checks++;
        if ({id_valid, ibus_req_o, ibus_adr_o} !== {1'b0, 1'b1, 32'h1040_0000})
            begin n_fail++; $display("FAIL mapped_req: got v=%b req=%b adr=%h, want v=0 req=1 adr=10400000", id_valid, ibus_req_o, ibus_adr_o); end
        ibus_err_i = 1'b1;
        tick();
        ibus_err_i = 1'b0;
        n_checks++;
        if ({ibus_req_o, id_valid, id_pc, id_insn, exc} !== {1'b0, 1'b1, 32'h0040_0000, 32'h0, 5'b10000})
            begin n_fail++; $display("FAIL err_marker: got req=%b v=%b pc=%h insn=%h exc=%b, want req=0 v=1 pc=00400000 insn=0 exc=10000", ibus_req_o, id_valid, id_pc, id_insn, exc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({ibus_req_o, id_valid, exc} !== {1'b0, 1'b0, 5'b0})
                begin n_fail++; $display("FAIL err_halt%0d: got req=%b v=%b exc=%b, want req=0 v=0 exc=00000", i, ibus_req_o, id_valid, exc); end
        end
    endtask

    task automatic test_reset_mid();
        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'hE000_4000;
        tick();
        ex_redirect = 1'b0;
        n_checks++;
        if ({ibus_req_o, ibus_adr_o} !== {1'b1, 32'h2000_4000})
            begin n_fail++; $display("FAIL midrst_req: got req=%b adr=%h, want req=1 adr=20004000", ibus_req_o, ibus_adr_o); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ibus_req_o, ibus_adr_o, id_valid} !== {1'b0, 32'h0, 1'b0})
            begin n_fail++; $display("FAIL midrst_async: got req=%b adr=%h v=%b, want req=0 adr=00000000 v=0", ibus_req_o, ibus_adr_o, id_valid); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({ibus_req_o, ibus_adr_o} !== {1'b1, 32'h2000_0000})
            begin n_fail++; $display("FAIL midrst_restart: got req=%b adr=%h, want req=1 adr=20000000", ibus_req_o, ibus_adr_o); end
    endtask

    initial begin
        rst            = 1'b1;
        id_stall       = 1'b0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = 32'h0;
        if_user_mode   = 1'b0;
        itlb_miss      = 1'b0;
        itlb_invalid   = 1'b0;
        ibus_ack_i     = 1'b0;
        ibus_err_i     = 1'b0;
        ibus_dat_i     = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_discard();
        test_redirect_ack();
        test_tlb_faults();
        test_mapped_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
